// File: rtl/fsmc_mailbox_regs_if.sv
// rtl/fsmc_mailbox_regs_if.sv - register bus and TX/RX stream signals of the FSMC mailbox
interface fsmc_mailbox_regs_if #(
  parameter int ADRW = 2,
  parameter int DATW = 3
);
  logic            do_write;
  logic            do_read;
  logic [ADRW-1:0] rw_adr;
  logic [DATW-1:0] w_data;
  logic [DATW-1:0] read_data;
  logic            tx_valid;
  logic [DATW-1:0] tx_data;
  logic            tx_ready;
  logic            rx_valid;
  logic [DATW-1:0] rx_data;
  logic            rx_ready;

  // bus slave and fabric side driving the mailbox
  modport master (
    output do_write, do_read, rw_adr, w_data, tx_ready, rx_valid, rx_data,
    input  read_data, tx_valid, tx_data, rx_ready
  );

  // mailbox register block
  modport slave (
    input  do_write, do_read, rw_adr, w_data, tx_ready, rx_valid, rx_data,
    output read_data, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/fsmc_mailbox_regs.sv
// rtl/fsmc_mailbox_regs.sv - FSMC mailbox: TX/RX FIFOs with status/control registers; optional irq via FSMC_MAILBOX_IRQ_EN
module fsmc_mailbox_regs #(
  parameter int ADRW       = 2,
  parameter int DATW       = 3,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic clk,
  input  logic rst,
`ifdef FSMC_MAILBOX_IRQ_EN
  output logic irq,
`endif
  fsmc_mailbox_regs_if.slave bus
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int OCC_MAX = (1 << DATW) - 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [DATW-1:0] tx_mem [DEPTH];
  logic [DATW-1:0] rx_mem [DEPTH];
  ptr_t tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  cnt_t tx_count, rx_count;
  logic tx_ovf, rx_udf;

  logic [1:0] adr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic ctrl_wr, flush_tx, flush_rx, clr_err;
  logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic rx_pop_req, rx_push, rx_pop, rx_udf_set;
  logic irq_bit;
  logic [3:0] stat4;
  logic [DATW-1:0] tx_occ;

  // only the low two address bits select a register
  assign adr = bus.rw_adr[1:0];

  assign tx_full  = (tx_count == cnt_t'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == cnt_t'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign ctrl_wr  = bus.do_write & (adr == 2'd3);
  assign flush_tx = ctrl_wr & bus.w_data[0];
  assign flush_rx = ctrl_wr & bus.w_data[1];
  assign clr_err  = ctrl_wr & bus.w_data[2];

  // full/empty come from registered counts, so a same-cycle pop never rescues a push into a full FIFO
  assign tx_push_req = bus.do_write & (adr == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full & ~flush_tx;
  assign tx_ovf_set  = tx_push_req & tx_full & ~flush_tx;
  assign tx_pop      = ~tx_empty & bus.tx_ready & ~flush_tx;

  assign rx_push     = bus.rx_valid & ~rx_full & ~flush_rx;
  assign rx_pop_req  = bus.do_read & (adr == 2'd1);
  assign rx_pop      = rx_pop_req & ~rx_empty & ~flush_rx;
  assign rx_udf_set  = rx_pop_req & rx_empty;

  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_mem[tx_rd_ptr];
  assign bus.rx_ready = ~rx_full;

`ifdef FSMC_MAILBOX_IRQ_EN
  // irq follows (rx_nonempty | err) with one cycle of delay
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ~rx_empty | tx_ovf | rx_udf;
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  // bit3 falls away automatically when DATW is 3
  assign stat4 = {irq_bit, tx_ovf | rx_udf, ~rx_empty, tx_full};

  // TX occupancy can reach DEPTH, which may not fit in DATW bits
  assign tx_occ = (int'(tx_count) > OCC_MAX) ? DATW'(OCC_MAX) : DATW'(tx_count);

  // register read mux, combinational so the bus slave can latch it in the strobe cycle
  always_comb begin
    bus.read_data = '0;
    case (adr)
      2'd0: bus.read_data = tx_occ;
      2'd1: bus.read_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];
      2'd2: bus.read_data = DATW'(stat4);
      default: bus.read_data = '0;
    endcase
  end

  // FIFO storage writes; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem[tx_wr_ptr] <= bus.w_data;
    if (!rst && rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  // TX pointers and count; flush discards everything including a same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || flush_tx) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
      tx_count <= tx_count + cnt_t'(tx_push) - cnt_t'(tx_pop);
    end
  end

  // RX pointers and count; flush discards everything including a same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || flush_rx) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
      rx_count <= rx_count + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end

  // sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~clr_err);
      rx_udf <= rx_udf_set | (rx_udf & ~clr_err);
    end
  end
endmodule

// File: doc/fsmc_mailbox_regs.md
Name: fsmc_mailbox_regs

Overview:
- Register/mailbox stage directly downstream of the clocked FSMC bus slave.
- Consumes the slave's one-cycle do_write/do_read strobes, rw_adr and w_data, and returns read_data.
- Two FIFOs:
  - TX: MCU to fabric.
  - RX: fabric to MCU.
- Status and control registers, so the STM32 can stream data through the 3-bit FSMC data path without polling every word.

Parameters:
ADRW, 2, bus address width; only values 0..3 decoded, higher address bits ignored
DATW, 3, data width; minimum 3 (status/control bits)
DEPTH_LOG2, 3, log2 of each FIFO depth (default depth 8)

Ports:
clk  in  1  system clock (PLL domain, same as bus slave)
rst  in  1  synchronous reset, active-high
do_write  in  1  one-cycle write strobe from bus slave
do_read  in  1  one-cycle read strobe from bus slave
rw_adr  in  ADRW  register address, stable while strobes high
w_data  in  DATW  write data
read_data  out  DATW  read data, combinational from rw_adr and registered state
tx_valid  out  1  TX FIFO non-empty
tx_data  out  DATW  TX FIFO head
tx_ready  in  1  fabric consumes TX head when tx_valid & tx_ready
rx_valid  in  1  fabric offers word to RX FIFO
rx_data  in  DATW  fabric word
rx_ready  out  1  RX FIFO not full

Behaviour:
- Register map:
  - 0: write pushes TX FIFO; read returns TX occupancy, saturated to DATW bits.
  - 1: read returns RX head and pops it; writes ignored.
  - 2: STATUS, read-only:
    - bit0 tx_full
    - bit1 rx_nonempty
    - bit2 err = tx_ovf | rx_udf
    - upper bits 0
  - 3: CONTROL, write-only, reads return 0:
    - w_data[0] flush TX
    - w_data[1] flush RX
    - w_data[2] clear err flags
- read_data is combinational, valid in the same cycle as do_read, because the bus slave latches it at the end of that cycle. Pop side effects commit at that same clock edge.
- Each FIFO:
  - Circular buffer with rd/wr pointers of DEPTH_LOG2 bits and a count of DEPTH_LOG2+1 bits.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - full = (count == DEPTH); empty = (count == 0).
- TX push:
  - On do_write & adr==0 & !tx_full.
  - If tx_full, the word is dropped and tx_ovf is set (sticky). This holds even if the fabric pops in the same cycle; full is evaluated from registered count.
- TX pop: on tx_valid & tx_ready.
- RX push: on rx_valid & rx_ready. rx_ready = !rx_full, a registered-state function with no combinational path from rx_valid.
- RX pop:
  - On do_read & adr==1 & rx_nonempty.
  - If empty: read_data = 0, no pointer change, rx_udf set (sticky).
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen and count is unchanged.
- Push and pop on an empty TX/RX: the push occurs; the pop is not allowed (valid/nonempty is low).
- Flush: sets pointers and count to 0 that edge. Flush wins over any same-cycle push or pop on that FIFO; the pushed word is discarded and no ovf is set.
- Clear err: clears both sticky flags. If a new overflow or underflow occurs in the same cycle, set wins.
- Strobes are single-cycle. Back-to-back strobes on consecutive cycles must be handled; each is an independent transaction.
- Reset (synchronous):
  - All pointers, counts, tx_ovf and rx_udf go to 0.
  - tx_valid=0, rx_ready=1, read_data reflects the reset state.
  - Storage contents are undefined; tx_data is don't-care while tx_valid=0.
  - Reset mid-transaction aborts it; a strobe asserted with rst has no effect.
- Latency:
  - A word written at edge N appears at tx_valid/tx_data after edge N.
  - An RX word accepted at edge N is readable from edge N onward (status bit1 set).

Optional Feature:
FSMC_MAILBOX_IRQ_EN:
- Defined: adds output port irq (1 bit, registered) and STATUS bit3 irq_pending (requires DATW≥4; otherwise bit dropped).
  - irq goes high one cycle after any edge where rx_nonempty or err is true, and low one cycle after both are false.
  - Reset value 0.
- Undefined: no irq port, no extra logic; STATUS bit3 does not exist (reads 0 if DATW≥4).

Test Plan:
- After reset: read adr2 -> 3'b000; rx_ready=1, tx_valid=0; read adr0 -> 0.
- Write 5,3,6 to adr0 with tx_ready=0 -> tx_valid=1, tx_data=5, adr0 reads 3. Then raise tx_ready for 3 cycles -> tx_data sequence 5,3,6, then tx_valid=0.
- Write 8 words to adr0 with tx_ready=0, then a 9th (value 7) -> STATUS=3'b101. Drain shows only the first 8 words. Write adr3 with 3'b100 -> STATUS=3'b001 until the first pop, then 3'b000.
- Fabric pushes 1,2 -> STATUS bit1=1. do_read adr1 twice -> read_data 1 then 2. Third read -> 0 and STATUS bit2=1.
- Simultaneous: 4 words in RX, fabric push and MCU pop in the same cycle -> count stays 4, order preserved across pointer wrap (run 20 words through depth 8).
- Flush RX (adr3=3'b010) in the same cycle as rx_valid -> RX empty, word lost, err=0. Assert rst while TX holds data -> tx_valid=0 next cycle.
